rocc_dispatch: RTL and testbench

- Multi-accelerator RoCC functional unit for the issue/execute stage.
- Buffers RoCC commands from issue in a command FIFO and routes each one to one of NR_ACCEL accelerator ports.
- Tracks outstanding commands that expect a response in a tag table, so several can be in flight at once.
- Returns results on the standard FU writeback interface (trans_id/result/valid) and handles pipeline flush.

---
 rtl/rocc_pkg.sv | 51 +++++
 rtl/rocc_cmd_fifo.sv | 68 ++++++
 rtl/rocc_dispatch.sv | 162 ++++++++++++++++
 tb/tb_rocc_dispatch.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_pkg.sv
//------------------------------------------------------------------------------
// rocc_pkg : shared types, widths and helpers for the RoCC dispatch unit
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rocc_pkg;

    localparam int XLEN           = 64;
    localparam int TRANS_ID_BITS  = 3;
    localparam int CMD_DEPTH      = 4;
    localparam int NR_OUTSTANDING = 4;
    localparam int NR_ACCEL       = 2;
    localparam int TAG_BITS       = (NR_OUTSTANDING > 1) ? $clog2(NR_OUTSTANDING) : 1;
    localparam int SEL_BITS       = (NR_ACCEL > 1) ? $clog2(NR_ACCEL) : 1;

    typedef struct packed {
        logic [6:0]               funct7;
        logic [4:0]               rd;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic                     xd;
        logic [SEL_BITS-1:0]      accel;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } rocc_cmd_t;

    typedef struct packed {
        logic [6:0]          funct7;
        logic [4:0]          rd;
        logic [XLEN-1:0]     rs1;
        logic [XLEN-1:0]     rs2;
        logic                xd;
        logic [TAG_BITS-1:0] tag;
    } rocc_acc_cmd_t;

    typedef struct packed {
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     data;
    } rocc_acc_resp_t;

    // Index of the lowest clear bit; 0 when none is clear (callers gate on that case).
    function automatic logic [TAG_BITS-1:0] first_clear(input logic [NR_OUTSTANDING-1:0] vec);
        first_clear = '0;
        for (int i = NR_OUTSTANDING - 1; i >= 0; i--) begin
            if (!vec[i]) first_clear = TAG_BITS'(i);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/rocc_cmd_fifo.sv
//------------------------------------------------------------------------------
// rocc_cmd_fifo : registered-output FIFO with full/empty and synchronous flush
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rocc_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] PTR_ONE = 1;

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                     (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PTR_BITS-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i && !full_o) begin
                mem_d[wr_ptr_q[PTR_BITS-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rocc_dispatch.sv
//------------------------------------------------------------------------------
// rocc_dispatch : RoCC functional unit - command queue, accelerator routing,
//                 outstanding-tag tracking and FU writeback with flush support
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rocc_dispatch
    import rocc_pkg::*;
(
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                cmd_valid_i,
    output logic                                cmd_ready_o,
    input  rocc_cmd_t                           cmd_i,
    output logic           [NR_ACCEL-1:0]       acc_cmd_valid_o,
    input  logic           [NR_ACCEL-1:0]       acc_cmd_ready_i,
    output rocc_acc_cmd_t                       acc_cmd_o,
    input  logic           [NR_ACCEL-1:0]       acc_resp_valid_i,
    output logic           [NR_ACCEL-1:0]       acc_resp_ready_o,
    input  rocc_acc_resp_t [NR_ACCEL-1:0]       acc_resp_i,
    output logic           [TRANS_ID_BITS-1:0]  rocc_trans_id_o,
    output logic           [XLEN-1:0]           result_o,
    output logic                                rocc_valid_o,
    output logic                                busy_o
);

    localparam int CMD_W = $bits(rocc_cmd_t);

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CMD_W-1:0] fifo_rdata;
    rocc_cmd_t        head;

    logic [NR_OUTSTANDING-1:0] tag_valid_q, tag_valid_d;
    logic [NR_OUTSTANDING-1:0] tag_squash_q, tag_squash_d;
    logic [TRANS_ID_BITS-1:0]  tag_tid_q [NR_OUTSTANDING];
    logic [TRANS_ID_BITS-1:0]  tag_tid_d [NR_OUTSTANDING];

    logic                     wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]          wb_result_q, wb_result_d;
    logic [TRANS_ID_BITS-1:0] wb_tid_q, wb_tid_d;

    logic                free_tag_exists;
    logic [TAG_BITS-1:0] free_tag;
    logic                any_resp, resp_hit;
    logic [SEL_BITS-1:0] resp_sel;
    rocc_acc_resp_t      resp;
    logic                head_bad, head_xd, disp_ok, disp_fire;

    // Ready is forced low while reset is held so every output reads zero.
    assign cmd_ready_o = rst_ni && !fifo_full && !flush_i;
    assign fifo_push   = cmd_valid_i && cmd_ready_o;
    assign head        = rocc_cmd_t'(fifo_rdata);

    rocc_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .data_i  (CMD_W'(cmd_i)),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        free_tag_exists = ~&tag_valid_q;
        free_tag        = first_clear(tag_valid_q);

        // Fixed priority: scanning downward leaves the lowest valid channel selected.
        any_resp         = |acc_resp_valid_i;
        resp_sel         = '0;
        acc_resp_ready_o = '0;
        for (int i = NR_ACCEL - 1; i >= 0; i--) begin
            if (acc_resp_valid_i[i]) begin
                resp_sel         = SEL_BITS'(i);
                acc_resp_ready_o = '0;
                acc_resp_ready_o[i] = rst_ni;
            end
        end
        resp     = acc_resp_i[resp_sel];
        resp_hit = any_resp && tag_valid_q[resp.tag] && !tag_squash_q[resp.tag];

        // Out-of-range accelerator ids complete locally like a no-result command.
        head_bad = int'(head.accel) >= NR_ACCEL;
        head_xd  = head.xd && !head_bad;
        disp_ok  = !fifo_empty && !flush_i && (head_xd ? free_tag_exists : !any_resp);
        acc_cmd_valid_o = '0;
        if (disp_ok && !head_bad) acc_cmd_valid_o[head.accel] = 1'b1;
        disp_fire = disp_ok && (head_bad || acc_cmd_ready_i[head.accel]);
        fifo_pop  = disp_fire;

        acc_cmd_o.funct7 = head.funct7;
        acc_cmd_o.rd     = head.rd;
        acc_cmd_o.rs1    = head.rs1;
        acc_cmd_o.rs2    = head.rs2;
        acc_cmd_o.xd     = head.xd;
        acc_cmd_o.tag    = free_tag;
    end

    always_comb begin
        tag_valid_d  = tag_valid_q;
        tag_squash_d = tag_squash_q;
        tag_tid_d    = tag_tid_q;
        if (flush_i) tag_squash_d = tag_squash_q | tag_valid_q;
        if (any_resp) begin
            tag_valid_d[resp.tag]  = 1'b0;
            tag_squash_d[resp.tag] = 1'b0;
        end
        if (disp_fire && head_xd) begin
            tag_valid_d[free_tag]  = 1'b1;
            tag_squash_d[free_tag] = 1'b0;
            tag_tid_d[free_tag]    = head.trans_id;
        end

        wb_valid_d  = 1'b0;
        wb_result_d = wb_result_q;
        wb_tid_d    = wb_tid_q;
        if (!flush_i) begin
            if (resp_hit) begin
                wb_valid_d  = 1'b1;
                wb_result_d = resp.data;
                wb_tid_d    = tag_tid_q[resp.tag];
            end else if (disp_fire && !head_xd) begin
                wb_valid_d  = 1'b1;
                wb_result_d = '0;
                wb_tid_d    = head.trans_id;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_valid_q  <= '0;
            tag_squash_q <= '0;
            for (int i = 0; i < NR_OUTSTANDING; i++) tag_tid_q[i] <= '0;
            wb_valid_q   <= 1'b0;
            wb_result_q  <= '0;
            wb_tid_q     <= '0;
        end else begin
            tag_valid_q  <= tag_valid_d;
            tag_squash_q <= tag_squash_d;
            tag_tid_q    <= tag_tid_d;
            wb_valid_q   <= wb_valid_d;
            wb_result_q  <= wb_result_d;
            wb_tid_q     <= wb_tid_d;
        end
    end

    assign rocc_valid_o    = wb_valid_q;
    assign result_o        = wb_result_q;
    assign rocc_trans_id_o = wb_tid_q;
    assign busy_o          = !fifo_empty || (|tag_valid_q);

endmodule

`default_nettype wire

// File: tb/tb_rocc_dispatch.sv
//------------------------------------------------------------------------------
// tb_rocc_dispatch : directed self-checking bench for rocc_dispatch
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rocc_dispatch;
    import rocc_pkg::*;

    logic                                clk_i = 1'b0;
    logic                                rst_ni;
    logic                                flush_i;
    logic                                cmd_valid_i;
    logic                                cmd_ready_o;
    rocc_cmd_t                           cmd_i;
    logic           [NR_ACCEL-1:0]       acc_cmd_valid_o;
    logic           [NR_ACCEL-1:0]       acc_cmd_ready_i;
    rocc_acc_cmd_t                       acc_cmd_o;
    logic           [NR_ACCEL-1:0]       acc_resp_valid_i;
    logic           [NR_ACCEL-1:0]       acc_resp_ready_o;
    rocc_acc_resp_t [NR_ACCEL-1:0]       acc_resp_i;
    logic           [TRANS_ID_BITS-1:0]  rocc_trans_id_o;
    logic           [XLEN-1:0]           result_o;
    logic                                rocc_valid_o;
    logic                                busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    rocc_dispatch u_dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_i            (cmd_i),
        .acc_cmd_valid_o  (acc_cmd_valid_o),
        .acc_cmd_ready_i  (acc_cmd_ready_i),
        .acc_cmd_o        (acc_cmd_o),
        .acc_resp_valid_i (acc_resp_valid_i),
        .acc_resp_ready_o (acc_resp_ready_o),
        .acc_resp_i       (acc_resp_i),
        .rocc_trans_id_o  (rocc_trans_id_o),
        .result_o         (result_o),
        .rocc_valid_o     (rocc_valid_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the falling edge; outputs are read 1 unit later.
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic xd, input logic [SEL_BITS-1:0] acc,
                           input logic [TRANS_ID_BITS-1:0] tid, input logic [XLEN-1:0] rs1);
        cmd_valid_i     = v;
        cmd_i           = '0;
        cmd_i.funct7    = 7'h11;
        cmd_i.rd        = 5'd1;
        cmd_i.rs1       = rs1;
        cmd_i.rs2       = rs1 + 64'd1;
        cmd_i.xd        = xd;
        cmd_i.accel     = acc;
        cmd_i.trans_id  = tid;
    endtask

    task automatic set_resp(input int ch, input logic [TAG_BITS-1:0] tag, input logic [XLEN-1:0] data);
        acc_resp_valid_i[ch] = 1'b1;
        acc_resp_i[ch].tag   = tag;
        acc_resp_i[ch].data  = data;
    endtask

    initial begin
        logic [TRANS_ID_BITS-1:0] drain_tid [4];
        drain_tid[0] = 3'd0; drain_tid[1] = 3'd1; drain_tid[2] = 3'd4; drain_tid[3] = 3'd3;

        rst_ni           = 1'b1;
        flush_i          = 1'b0;
        acc_cmd_ready_i  = 2'b11;
        acc_resp_valid_i = '0;
        acc_resp_i       = '0;
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("rst_cmd_ready", cmd_ready_o, 0);
        check_eq("rst_acc_valid", acc_cmd_valid_o, 0);
        check_eq("rst_rocc_valid", rocc_valid_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_result", result_o, 0);
        step(); step();
        rst_ni = 1'b1;
        #1;
        check_eq("rel_cmd_ready", cmd_ready_o, 1);

        // Single xd command on accelerator 1.
        step();
        set_cmd(1'b1, 1'b1, 1'b1, 3'd5, 64'd3);
        step();
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        #1;
        check_eq("t1_acc_valid", acc_cmd_valid_o, 2'b10);
        check_eq("t1_tag", acc_cmd_o.tag, 0);
        check_eq("t1_rs1", acc_cmd_o.rs1, 3);
        check_eq("t1_rs2", acc_cmd_o.rs2, 4);
        step();
        check_eq("t1_busy", busy_o, 1);
        check_eq("t1_acc_idle", acc_cmd_valid_o, 0);
        step();
        step();
        set_resp(1, 2'd0, 64'h7);
        #1;
        check_eq("t1_resp_ready", acc_resp_ready_o, 2'b10);
        step();
        acc_resp_valid_i = '0;
        check_eq("t1_wb_valid", rocc_valid_o, 1);
        check_eq("t1_wb_result", result_o, 64'h7);
        check_eq("t1_wb_tid", rocc_trans_id_o, 5);
        step();
        check_eq("t1_wb_pulse", rocc_valid_o, 0);
        check_eq("t1_result_hold", result_o, 64'h7);
        check_eq("t1_idle", busy_o, 0);

        // Five xd commands against four tags.
        for (int k = 0; k < 5; k++) begin
            step();
            set_cmd(1'b1, 1'b1, 1'b0, TRANS_ID_BITS'(k), 64'(16 + k));
            #1;
            check_eq("t2_cmd_ready", cmd_ready_o, 1);
            if (k >= 1) begin
                check_eq("t2_acc_valid", acc_cmd_valid_o, 2'b01);
                check_eq("t2_tag", acc_cmd_o.tag, 64'(k - 1));
            end
        end
        step();
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        #1;
        check_eq("t2_stall", acc_cmd_valid_o, 0);
        check_eq("t2_busy", busy_o, 1);
        step();
        set_resp(0, 2'd2, 64'h22);
        #1;
        check_eq("t2_no_same_cycle_realloc", acc_cmd_valid_o, 0);
        check_eq("t2_resp_ready", acc_resp_ready_o, 2'b01);
        step();
        acc_resp_valid_i = '0;
        #1;
        check_eq("t2_wb_valid", rocc_valid_o, 1);
        check_eq("t2_wb_result", result_o, 64'h22);
        check_eq("t2_wb_tid", rocc_trans_id_o, 2);
        check_eq("t2_5th_valid", acc_cmd_valid_o, 2'b01);
        check_eq("t2_5th_tag", acc_cmd_o.tag, 2);
        step();
        check_eq("t2_fifo_drained", acc_cmd_valid_o, 0);
        for (int t = 0; t < 4; t++) begin
            set_resp(0, TAG_BITS'(t), 64'(256 + t));
            step();
            acc_resp_valid_i = '0;
            check_eq("t2_drain_valid", rocc_valid_o, 1);
            check_eq("t2_drain_result", result_o, 64'(256 + t));
            check_eq("t2_drain_tid", rocc_trans_id_o, drain_tid[t]);
        end
        step();
        check_eq("t2_idle", busy_o, 0);

        // Simultaneous responses on both channels.
        set_cmd(1'b1, 1'b1, 1'b0, 3'd1, 64'd5);
        step();
        set_cmd(1'b1, 1'b1, 1'b1, 3'd6, 64'd6);
        step();
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        step();
        set_resp(0, 2'd0, 64'hA);
        set_resp(1, 2'd1, 64'hB);
        #1;
        check_eq("t3_grant_ch0", acc_resp_ready_o, 2'b01);
        step();
        acc_resp_valid_i[0] = 1'b0;
        #1;
        check_eq("t3_wb0_valid", rocc_valid_o, 1);
        check_eq("t3_wb0_result", result_o, 64'hA);
        check_eq("t3_wb0_tid", rocc_trans_id_o, 1);
        check_eq("t3_grant_ch1", acc_resp_ready_o, 2'b10);
        step();
        acc_resp_valid_i = '0;
        check_eq("t3_wb1_valid", rocc_valid_o, 1);
        check_eq("t3_wb1_result", result_o, 64'hB);
        check_eq("t3_wb1_tid", rocc_trans_id_o, 6);
        step();
        check_eq("t3_idle", busy_o, 0);

        // No-result command, then one delayed by a pending response.
        set_cmd(1'b1, 1'b0, 1'b0, 3'd2, 64'd9);
        step();
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        #1;
        check_eq("t4_acc_valid", acc_cmd_valid_o, 2'b01);
        step();
        check_eq("t4_wb_valid", rocc_valid_o, 1);
        check_eq("t4_wb_result", result_o, 0);
        check_eq("t4_wb_tid", rocc_trans_id_o, 2);
        set_cmd(1'b1, 1'b1, 1'b1, 3'd3, 64'h30);
        step();
        set_cmd(1'b1, 1'b0, 1'b0, 3'd4, 64'h40);
        step();
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        set_resp(1, 2'd0, 64'h55);
        #1;
        check_eq("t4_gated_by_resp", acc_cmd_valid_o, 0);
        step();
        acc_resp_valid_i = '0;
        #1;
        check_eq("t4_delayed_valid", acc_cmd_valid_o, 2'b01);
        check_eq("t4_resp_wb_result", result_o, 64'h55);
        check_eq("t4_resp_wb_tid", rocc_trans_id_o, 3);
        step();
        check_eq("t4_nxd_wb_valid", rocc_valid_o, 1);
        check_eq("t4_nxd_wb_result", result_o, 0);
        check_eq("t4_nxd_wb_tid", rocc_trans_id_o, 4);
        step();
        check_eq("t4_idle", busy_o, 0);

        // Flush with two outstanding and two queued.
        set_cmd(1'b1, 1'b1, 1'b0, 3'd1, 64'd1);
        step();
        set_cmd(1'b1, 1'b1, 1'b0, 3'd2, 64'd2);
        step();
        set_cmd(1'b1, 1'b1, 1'b0, 3'd3, 64'd3);
        step();
        set_cmd(1'b1, 1'b1, 1'b0, 3'd4, 64'd4);
        acc_cmd_ready_i = 2'b00;
        step();
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        #1;
        check_eq("t5_queued_valid", acc_cmd_valid_o, 2'b01);
        check_eq("t5_queued_tag", acc_cmd_o.tag, 2);
        step();
        flush_i = 1'b1;
        set_cmd(1'b1, 1'b1, 1'b0, 3'd5, 64'd5);
        #1;
        check_eq("t5_flush_ready", cmd_ready_o, 0);
        check_eq("t5_flush_no_disp", acc_cmd_valid_o, 0);
        step();
        flush_i = 1'b0;
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        acc_cmd_ready_i = 2'b11;
        #1;
        check_eq("t5_fifo_empty", acc_cmd_valid_o, 0);
        check_eq("t5_ready_back", cmd_ready_o, 1);
        check_eq("t5_busy_tags", busy_o, 1);
        set_resp(0, 2'd0, 64'h77);
        step();
        acc_resp_valid_i = '0;
        check_eq("t5_squashed0", rocc_valid_o, 0);
        check_eq("t5_busy_mid", busy_o, 1);
        set_resp(0, 2'd1, 64'h78);
        step();
        acc_resp_valid_i = '0;
        check_eq("t5_squashed1", rocc_valid_o, 0);
        check_eq("t5_busy_done", busy_o, 0);

        // Reset with the command FIFO full.
        set_cmd(1'b1, 1'b1, 1'b1, 3'd7, 64'd1);
        step();
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        step();
        set_resp(1, 2'd0, 64'h99);
        step();
        acc_resp_valid_i = '0;
        check_eq("t6_pre_result", result_o, 64'h99);
        acc_cmd_ready_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 1'b1, 1'b0, TRANS_ID_BITS'(i), 64'(i));
            step();
        end
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        #1;
        check_eq("t6_full", cmd_ready_o, 0);
        check_eq("t6_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_ready", cmd_ready_o, 0);
        check_eq("t6_rst_acc_valid", acc_cmd_valid_o, 0);
        check_eq("t6_rst_busy", busy_o, 0);
        check_eq("t6_rst_result", result_o, 0);
        check_eq("t6_rst_tid", rocc_trans_id_o, 0);
        step();
        rst_ni = 1'b1;
        acc_cmd_ready_i = 2'b11;
        #1;
        check_eq("t6_rel_ready", cmd_ready_o, 1);
        check_eq("t6_rel_valid", rocc_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
